// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_e     - controller FSM state (RUN=0, MUL_WAIT=1, FLUSH=2)
//   StallCntW/Max  - width and saturation value of the debug stall counter
//   CntW           - width of the multiply/flush down-counter
//   hz_params_ok() - legal-range check for the controller parameters
package hazard_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StRun     = 2'd0,
    StMulWait = 2'd1,
    StFlush   = 2'd2
  } hz_state_e;

  localparam int unsigned             StallCntW   = 16;
  localparam logic [StallCntW-1:0]    StallCntMax = 16'hFFFF;

  localparam int unsigned CntW = 4;

  localparam int unsigned MulLatMin   = 2;
  localparam int unsigned MulLatMax   = 15;
  localparam int unsigned FlushCycMin = 1;
  localparam int unsigned FlushCycMax = 15;

  function automatic bit hz_params_ok(input int unsigned mul_lat,
                                      input int unsigned flush_cycles);
    return (mul_lat >= MulLatMin) && (mul_lat <= MulLatMax) &&
           (flush_cycles >= FlushCycMin) && (flush_cycles <= FlushCycMax);
  endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// hz_sat_counter: up-counter that sticks at its maximum value.
//   clk_i   - clock
//   clr_ni  - synchronous active-low clear
//   en_i    - count enable
//   count_o - current count
module hz_sat_counter
  import hazard_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 clr_ni,
  input  logic                 en_i,
  output logic [StallCntW-1:0] count_o
);

  logic [StallCntW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      count_q <= '0;
    end else if (en_i && (count_q != StallCntMax)) begin
      count_q <= count_q + StallCntW'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage pipeline.
// Inputs:  clk, rst (sync, active low), ID source regs and use flags, EX dest reg,
//          EX load / multiply / taken-branch flags.
// Outputs: pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold (combinational),
//          busy, state (FSM), stall_cnt (saturating count of cycles with pc_write=0).
// All outputs are held at 0 while rst is low.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 3,
  parameter int unsigned MUL_LAT      = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_AW-1:0]    ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_is_mul,
  input  logic                 ex_branch_taken,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 ex_hold,
  output logic                 busy,
  output logic [StateW-1:0]    state,
  output logic [StallCntW-1:0] stall_cnt
);

  if (!hz_params_ok(MUL_LAT, FLUSH_CYCLES)) begin : g_param_check
    $error("hazard_ctrl: MUL_LAT must be 2..15 and FLUSH_CYCLES 1..15");
  end

  // Counter preloads: the RUN cycle that sees the event is the first hold/squash cycle,
  // and the wait state exits on the cycle it sees cnt==0.
  localparam logic [CntW-1:0] MulCntInit   = CntW'((MUL_LAT > 2) ? MUL_LAT - 3 : 0);
  localparam logic [CntW-1:0] FlushCntInit = CntW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  hz_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 load_use;
  logic                 pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, ex_hold_c;
  logic [StallCntW-1:0] stall_cnt_q;

  // R0 is a real register here, so no zero-register exclusion.
  assign load_use = ex_mem_read &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write_c    = 1'b0;
    ifid_write_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    ex_hold_c     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          // Squash looks the same as in FLUSH; a concurrent load-use is moot.
          pc_write_c    = 1'b1;
          ifid_write_c  = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            cnt_d   = FlushCntInit;
          end
        end else if (ex_is_mul) begin
          ex_hold_c = 1'b1;
          if (MUL_LAT > 2) begin
            state_d = StMulWait;
            cnt_d   = MulCntInit;
          end
        end else if (load_use) begin
          idex_bubble_c = 1'b1;
        end else begin
          pc_write_c   = 1'b1;
          ifid_write_c = 1'b1;
        end
      end
      StMulWait: begin
        ex_hold_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFlush: begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  hz_sat_counter u_stall_cnt (
    .clk_i   (clk),
    .clr_ni  (rst),
    .en_i    (rst && !pc_write_c),
    .count_o (stall_cnt_q)
  );

  assign pc_write    = rst && pc_write_c;
  assign ifid_write  = rst && ifid_write_c;
  assign ifid_flush  = rst && ifid_flush_c;
  assign idex_bubble = rst && idex_bubble_c;
  assign ex_hold     = rst && ex_hold_c;
  assign busy        = rst && (state_q != StRun);
  assign state       = rst ? state_q : StRun;
  assign stall_cnt   = rst ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand-written multi-cycle sequences, and
// randomized stimulus against a remaining-cycles reference model on two
// parameterizations (4/2 and the 2/1 boundary).
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_mul, ex_branch_taken;

  logic        pc_write0, ifid_write0, ifid_flush0, idex_bubble0, ex_hold0, busy0;
  logic [1:0]  state0;
  logic [15:0] stall_cnt0;
  logic        pc_write1, ifid_write1, ifid_flush1, idex_bubble1, ex_hold1, busy1;
  logic [1:0]  state1;
  logic [15:0] stall_cnt1;

  hazard_ctrl #(.REG_AW(3), .MUL_LAT(4), .FLUSH_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write0), .ifid_write(ifid_write0),
    .ifid_flush(ifid_flush0), .idex_bubble(idex_bubble0), .ex_hold(ex_hold0), .busy(busy0),
    .state(state0), .stall_cnt(stall_cnt0)
  );

  hazard_ctrl #(.REG_AW(3), .MUL_LAT(2), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write1), .ifid_write(ifid_write1),
    .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1), .ex_hold(ex_hold1), .busy(busy1),
    .state(state1), .stall_cnt(stall_cnt1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, busy, state[1:0]}
  function automatic logic [7:0] outs(input int k);
    if (k == 0) return {pc_write0, ifid_write0, ifid_flush0, idex_bubble0, ex_hold0, busy0, state0};
    return {pc_write1, ifid_write1, ifid_flush1, idex_bubble1, ex_hold1, busy1, state1};
  endfunction

  function automatic logic [15:0] scnt(input int k);
    return (k == 0) ? stall_cnt0 : stall_cnt1;
  endfunction

  task automatic idle();
    id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_is_mul = 1'b0; ex_branch_taken = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst released and state freshly reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- reference model: remaining extra cycles per mode ----------------
  int hold_left[2];
  int flush_left[2];
  int sc[2];

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int fcy(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [7:0] model_out(input int k);
    logic lu;
    lu = ex_mem_read && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!rst) return 8'h00;
    if (hold_left[k] > 0)  return {5'b00001, 1'b1, 2'd1};
    if (flush_left[k] > 0) return {5'b11110, 1'b1, 2'd2};
    if (ex_branch_taken)   return {5'b11110, 1'b0, 2'd0};
    if (ex_is_mul)         return {5'b00001, 1'b0, 2'd0};
    if (lu)                return {5'b00010, 1'b0, 2'd0};
    return {5'b11000, 1'b0, 2'd0};
  endfunction

  task automatic model_step(input int k, input logic [7:0] o);
    if (!rst) begin
      hold_left[k] = 0; flush_left[k] = 0; sc[k] = 0;
    end else begin
      if (!o[7] && sc[k] < 65535) sc[k]++;
      if (hold_left[k] > 0)       hold_left[k]--;
      else if (flush_left[k] > 0) flush_left[k]--;
      else if (ex_branch_taken)   flush_left[k] = fcy(k) - 1;
      else if (ex_is_mul)         hold_left[k] = lat(k) - 2;
    end
  endtask

  // ---------------- vector table (instance 0, from RUN) ----------------
  typedef struct {
    logic [2:0] rs1, rs2, rd;
    logic       u1, u2, mr, mul, br;
    logic [4:0] ctrl;   // {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold}
    logic [1:0] st;     // state after the edge
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0]  o, e;
    logic [7:0]  seq;
    int          n_hold, n_busy, n_flush, n_bub, n_pc;
    logic [15:0] sc_before;

    rst = 1'b0;
    idle();

    // Reset forces outputs low even with hazards asserted.
    ex_mem_read = 1'b1; ex_rd = 3'd2; id_rs1 = 3'd2; id_uses_rs1 = 1'b1; ex_is_mul = 1'b1;
    #1;
    chk("reset_outs_pre_edge", {24'd0, outs(0)}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {24'd0, outs(0)}, 32'd0);
    chk("reset_stall_cnt", {16'd0, stall_cnt0}, 32'd0);

    //             rs1   rs2   rd    u1 u2 mr mul br  ctrl       st
    vecs[0]  = '{3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 5'b11000, 2'd0};
    vecs[1]  = '{3'd5, 3'd1, 3'd5, 1, 0, 1, 0, 0, 5'b00010, 2'd0};
    vecs[2]  = '{3'd1, 3'd3, 3'd3, 0, 1, 1, 0, 0, 5'b00010, 2'd0};
    vecs[3]  = '{3'd0, 3'd7, 3'd0, 1, 0, 1, 0, 0, 5'b00010, 2'd0};
    vecs[4]  = '{3'd5, 3'd5, 3'd5, 0, 0, 1, 0, 0, 5'b11000, 2'd0};
    vecs[5]  = '{3'd5, 3'd5, 3'd5, 1, 1, 0, 0, 0, 5'b11000, 2'd0};
    vecs[6]  = '{3'd4, 3'd6, 3'd5, 1, 1, 1, 0, 0, 5'b11000, 2'd0};
    vecs[7]  = '{3'd0, 3'd0, 3'd1, 0, 0, 0, 1, 0, 5'b00001, 2'd1};
    vecs[8]  = '{3'd2, 3'd0, 3'd2, 1, 0, 1, 1, 0, 5'b00001, 2'd1};
    vecs[9]  = '{3'd0, 3'd0, 3'd1, 0, 0, 0, 0, 1, 5'b11110, 2'd2};
    vecs[10] = '{3'd6, 3'd0, 3'd6, 1, 0, 1, 0, 1, 5'b11110, 2'd2};
    vecs[11] = '{3'd0, 3'd0, 3'd1, 0, 0, 0, 1, 1, 5'b11110, 2'd2};

    for (int i = 0; i < 12; i++) begin
      do_reset();
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_mem_read = vecs[i].mr; ex_is_mul = vecs[i].mul; ex_branch_taken = vecs[i].br;
      #1;
      o = outs(0);
      chk($sformatf("vec%0d_ctrl", i), {27'd0, o[7:3]}, {27'd0, vecs[i].ctrl});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_state", i), {30'd0, state0}, {30'd0, vecs[i].st});
    end

    // Single load-use stall.
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_uses_rs2 = 1'b1;
    #1;
    o = outs(0);
    chk("lu_ctrl", {24'd0, o}, {24'd0, 8'b00010_0_00});
    @(posedge clk);
    #1;
    chk("lu_state", {30'd0, state0}, 32'd0);
    chk("lu_stall_cnt", {16'd0, stall_cnt0}, 32'd1);
    idle();

    // Multiply held in EX; mul flag stays up through MUL_WAIT, which must ignore it.
    do_reset();
    n_hold = 0; n_busy = 0; seq = '0;
    for (int i = 0; i < 5; i++) begin
      ex_is_mul = (i < 3);
      #1;
      n_hold += int'(ex_hold0);
      n_busy += int'(busy0);
      if (i < 4) seq = {seq[5:0], state0};
      @(negedge clk);
    end
    chk("mul_hold_cycles", n_hold, 3);
    chk("mul_busy_cycles", n_busy, 2);
    chk("mul_state_seq", {24'd0, seq}, {24'd0, 8'b00_01_01_00});
    chk("mul_stall_cnt", {16'd0, stall_cnt0}, 32'd3);

    // Taken branch; the multiply arriving during FLUSH is squashed.
    do_reset();
    sc_before = stall_cnt0;
    n_flush = 0; n_bub = 0; n_pc = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      ex_branch_taken = (i == 0);
      ex_is_mul = (i == 1);
      #1;
      n_flush += int'(ifid_flush0);
      n_bub   += int'(idex_bubble0);
      n_pc    += int'(pc_write0);
      if (i == 2) chk("br_state_after", {30'd0, state0}, 32'd0);
      @(negedge clk);
    end
    chk("br_flush_cycles", n_flush, 2);
    chk("br_bubble_cycles", n_bub, 2);
    chk("br_pc_write_cycles", n_pc, 4);
    chk("br_stall_cnt", {16'd0, stall_cnt0}, {16'd0, sc_before});

    // Reset in the second hold cycle of a multiply.
    do_reset();
    ex_is_mul = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmul_outs", {24'd0, outs(0)}, 32'd0);
    chk("rstmul_cnt_during", {16'd0, stall_cnt0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ex_is_mul = 1'b0;
    #1;
    chk("rstmul_state", {30'd0, state0}, 32'd0);
    chk("rstmul_stall_cnt", {16'd0, stall_cnt0}, 32'd0);
    chk("rstmul_pc_write", {31'd0, pc_write0}, 32'd1);

    // Stall counter saturation.
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 3'd4; id_rs1 = 3'd4; id_uses_rs1 = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_near", {16'd0, stall_cnt0}, 32'h0000FFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, stall_cnt0}, 32'h0000FFFF);

    // Randomized run against the reference model on both instances.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      hold_left[k] = 0; flush_left[k] = 0; sc[k] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst             = ($urandom_range(0, 49) != 0);
      id_rs1          = 3'($urandom_range(0, 7));
      id_rs2          = 3'($urandom_range(0, 7));
      ex_rd           = 3'($urandom_range(0, 7));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_is_mul       = ($urandom_range(0, 6) == 0);
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        e = model_out(k);
        chk($sformatf("rand%0d_outs_c%0d", k, c), {24'd0, outs(k)}, {24'd0, e});
        chk($sformatf("rand%0d_stall_c%0d", k, c), {16'd0, scnt(k)},
            rst ? 32'(sc[k]) : 32'd0);
        model_step(k, e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage pipelined CPU. It watches the ID and EX stages and drives the stall and flush controls for the PC, IF/ID and ID/EX registers. It handles three cases: load-use stalls, a multi-cycle multiply holding EX, and taken-branch flushes. It sits beside the hazard/forwarding logic inside the CPU top level and also keeps a saturating stall-cycle counter for debug monitors.

## Interface
- REG_AW, 3, register-address width (8-entry register file)
- MUL_LAT, 4, cycles a multiply occupies EX; legal range 2..15
- FLUSH_CYCLES, 2, cycles of IF/ID + ID/EX squash after a taken branch; legal range 1..15
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads rs1/rs2
- ex_rd  in  REG_AW  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_is_mul  in  1  the EX instruction is a multiply
- ex_branch_taken  in  1  branch resolved taken in EX
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- ex_hold  out  1  freeze EX/ID/EX contents
- busy  out  1  FSM not in RUN
- state  out  2  FSM state: RUN=0, MUL_WAIT=1, FLUSH=2
- stall_cnt  out  16  saturating count of cycles with pc_write=0

## Operation
- Load-use condition: ex_mem_read && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)). All registers are real, including R0; there is no R0 exclusion.
- RUN state. Events are evaluated combinationally in the same cycle, in this priority:
  - ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2.
  - ex_is_mul: pc_write=0, ifid_write=0, ex_hold=1. If MUL_LAT>2, go to MUL_WAIT with cnt=MUL_LAT-3.
  - Load-use: pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. Stay in RUN (no state change).
  - Otherwise: pc_write=1, ifid_write=1, all other controls 0.
- MUL_WAIT: pc_write=0, ifid_write=0, ex_hold=1. ex_is_mul, ex_branch_taken and load-use are ignored. When cnt==0, go to RUN; otherwise decrement cnt.
- FLUSH: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Mul and load-use are ignored because those instructions are squashed. A new ex_branch_taken is ignored. When cnt==0, go to RUN; otherwise decrement cnt.
- Simultaneous events:
  - Branch + load-use: no stall.
  - ex_mem_read + ex_is_mul: mul wins.
- stall_cnt increments on every non-reset cycle with pc_write==0 and holds at 0xFFFF.

## Timing
- Controls are combinational from state and inputs (zero latency), so a stall takes effect at the same edge the hazard is seen.
- A multiply holds EX for MUL_LAT-1 cycles, so the mul is resident in EX for MUL_LAT cycles.
- A branch squashes for FLUSH_CYCLES consecutive cycles, starting the cycle ex_branch_taken is seen.
- Reset (rst=0 at a rising edge): state=RUN, cnt=0, stall_cnt=0. While rst=0, all outputs are forced to 0, including pc_write and ifid_write, and stall_cnt does not count.
- Reset mid-MUL_WAIT or mid-FLUSH aborts immediately. In the first cycle after rst returns to 1, the block is in RUN.
- cnt is 4 bits and is never decremented below 0.

## Structure
- Package hazard_pkg holds:
  - the state enum (RUN, MUL_WAIT, FLUSH) and the 2-bit state width;
  - the stall-counter width (16) and saturation constant 0xFFFF;
  - the parameter range checks.
- One sub-module, hz_sat_counter: 16-bit saturating up-counter with enable and synchronous active-low clear. It is instantiated for stall_cnt.
- The FSM, the cnt down-counter and the load-use comparator stay in hazard_ctrl.

## Test plan
- Load-use (MUL_LAT=4, FLUSH_CYCLES=2):
  - Stimulus: ex_mem_read=1, ex_rd=3, id_rs2=3, id_uses_rs2=1 for one cycle.
  - Response: pc_write=0, ifid_write=0, idex_bubble=1 that cycle; state stays 0; stall_cnt=1.
- Multiply:
  - Stimulus: ex_is_mul=1 held.
  - Response: ex_hold=1 for exactly 3 cycles; state sequence 0,1,1,0; busy=1 for 2 cycles; stall_cnt=3.
- Taken branch:
  - Stimulus: ex_branch_taken=1 pulse.
  - Response: ifid_flush=1 and idex_bubble=1 for 2 cycles; pc_write=1 throughout; stall_cnt unchanged.
- Priority:
  - Stimulus: branch_taken and the load-use condition in the same cycle.
  - Response: flush only, pc_write=1.
  - Stimulus: ex_mem_read=1 and ex_is_mul=1 together.
  - Response: MUL_WAIT entered.
- Reset mid-multiply:
  - Stimulus: rst=0 in the 2nd ex_hold cycle.
  - Response: all outputs 0 while rst=0; state=0, stall_cnt=0 on release.
- Saturation:
  - Stimulus: 65,540 consecutive load-use stall cycles.
  - Response: stall_cnt stops at 0xFFFF and does not wrap.
